// File: rtl/boot_pkg.sv
// ============================================================================
//  Module   : boot_pkg
//  Purpose  : Shared types and constants for the boot image copier.
//             Macro BOOT_CHECKSUM_EN adds the CHECK state to the encoding.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package boot_pkg;

  // Byte-select used for every RAM write (full 32-bit words only)
  localparam logic [3:0] SEL_FULL = 4'hf;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FREAD  = 3'd1,
    ST_RWRITE = 3'd2,
`ifdef BOOT_CHECKSUM_EN
    ST_CHECK  = 3'd3,
`endif
    ST_DONE   = 3'd4,
    ST_ERROR  = 3'd5
  } state_t;

  // Byte address of word 'index' relative to 'base', wrapping modulo 2^32
  function automatic logic [31:0] word_addr(input logic [31:0] base,
                                            input logic [31:0] index);
    return base + (index << 2);
  endfunction

endpackage

`default_nettype wire

// File: rtl/boot_wdog.sv
// ============================================================================
//  Module   : boot_wdog
//  Purpose  : Ack-timeout counter. Counts enabled cycles since the last clear
//             and flags expiry on the TIMEOUT-th consecutive enabled cycle.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module boot_wdog #(
  parameter int TIMEOUT = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  // Wait-cycle counter; clear has priority over counting
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CW'(1);
    end
  end

  assign expire = enable && (count == CW'(TIMEOUT - 1));

endmodule

`default_nettype wire

// File: rtl/boot_copier.sv
// ============================================================================
//  Module   : boot_copier
//  Purpose  : Wishbone master copying IMAGE_WORDS words from flash into RAM
//             after reset, then flagging programming complete. Optional
//             BOOT_CHECKSUM_EN macro adds a trailing checksum word compare.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module boot_copier
  import boot_pkg::*;
#(
  parameter logic [31:0] FLASH_ADDRESS = 32'hc000_0000,
  parameter logic [31:0] RAM_ADDR      = 32'h0000_0000,
  parameter int          IMAGE_WORDS   = 2048,
  parameter int          TIMEOUT       = 4096
) (
  input  logic        i_wb_clk,
  input  logic        i_wb_rst,
  input  logic        i_start,
  output logic [31:0] o_wb_flash_adr,
  output logic        o_wb_flash_cyc,
  input  logic [31:0] i_wb_flash_rdt,
  input  logic        i_wb_flash_ack,
  output logic [31:0] o_wb_ram_adr,
  output logic [31:0] o_wb_ram_dat,
  output logic [3:0]  o_wb_ram_sel,
  output logic        o_wb_ram_we,
  output logic        o_wb_ram_cyc,
  input  logic        i_wb_ram_ack,
  output logic        o_busy,
  output logic        o_prog_cmplt,
  output logic        o_error
);

  // One extra count so idx can point at the trailer word after the image
  localparam int             IW       = $clog2(IMAGE_WORDS + 1);
  localparam logic [IW-1:0]  LAST_IDX = IW'(IMAGE_WORDS - 1);

  state_t        state;
  logic [IW-1:0] idx;
  logic          expire;
  logic          cyc_active;
  logic          ack_taken;
`ifdef BOOT_CHECKSUM_EN
  logic [31:0]   sum;
`endif

  // Acks only count while the matching strobe is up
  assign cyc_active = o_wb_flash_cyc || o_wb_ram_cyc;
  assign ack_taken  = (o_wb_flash_cyc && i_wb_flash_ack) ||
                      (o_wb_ram_cyc && i_wb_ram_ack);

  boot_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk    (i_wb_clk),
    .rst    (i_wb_rst),
    .clear  (!cyc_active || ack_taken),
    .enable (cyc_active && !ack_taken),
    .expire (expire)
  );

  assign o_wb_ram_we = o_wb_ram_cyc;
  assign o_prog_cmplt = (state == ST_DONE);
  assign o_error      = (state == ST_ERROR);
`ifdef BOOT_CHECKSUM_EN
  assign o_busy = (state == ST_FREAD) || (state == ST_RWRITE) || (state == ST_CHECK);
`else
  assign o_busy = (state == ST_FREAD) || (state == ST_RWRITE);
`endif

  // Copy sequencer: each transfer raises cyc after a one-cycle gap, except
  // the very first read which starts straight out of IDLE
  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) begin
      state          <= ST_IDLE;
      idx            <= '0;
      o_wb_flash_adr <= '0;
      o_wb_flash_cyc <= 1'b0;
      o_wb_ram_adr   <= '0;
      o_wb_ram_dat   <= '0;
      o_wb_ram_sel   <= '0;
      o_wb_ram_cyc   <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      sum            <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            state          <= ST_FREAD;
            idx            <= '0;
            o_wb_flash_cyc <= 1'b1;
            o_wb_flash_adr <= FLASH_ADDRESS;
`ifdef BOOT_CHECKSUM_EN
            sum            <= '0;
`endif
          end
        end
        ST_FREAD: begin
          if (!o_wb_flash_cyc) begin
            o_wb_flash_cyc <= 1'b1;
            o_wb_flash_adr <= word_addr(FLASH_ADDRESS, 32'(idx));
          end else if (i_wb_flash_ack) begin
            o_wb_flash_cyc <= 1'b0;
            o_wb_ram_dat   <= i_wb_flash_rdt;
`ifdef BOOT_CHECKSUM_EN
            sum            <= sum + i_wb_flash_rdt;
`endif
            state          <= ST_RWRITE;
          end else if (expire) begin
            o_wb_flash_cyc <= 1'b0;
            state          <= ST_ERROR;
          end
        end
        ST_RWRITE: begin
          if (!o_wb_ram_cyc) begin
            o_wb_ram_cyc <= 1'b1;
            o_wb_ram_sel <= SEL_FULL;
            o_wb_ram_adr <= word_addr(RAM_ADDR, 32'(idx));
          end else if (i_wb_ram_ack) begin
            o_wb_ram_cyc <= 1'b0;
            o_wb_ram_sel <= '0;
            idx          <= idx + IW'(1);
            if (idx == LAST_IDX) begin
`ifdef BOOT_CHECKSUM_EN
              state <= ST_CHECK;
`else
              state <= ST_DONE;
`endif
            end else begin
              state <= ST_FREAD;
            end
          end else if (expire) begin
            o_wb_ram_cyc <= 1'b0;
            o_wb_ram_sel <= '0;
            state        <= ST_ERROR;
          end
        end
`ifdef BOOT_CHECKSUM_EN
        ST_CHECK: begin
          // idx already equals IMAGE_WORDS, so this reads the trailer word
          if (!o_wb_flash_cyc) begin
            o_wb_flash_cyc <= 1'b1;
            o_wb_flash_adr <= word_addr(FLASH_ADDRESS, 32'(idx));
          end else if (i_wb_flash_ack) begin
            o_wb_flash_cyc <= 1'b0;
            state          <= (i_wb_flash_rdt == sum) ? ST_DONE : ST_ERROR;
          end else if (expire) begin
            o_wb_flash_cyc <= 1'b0;
            state          <= ST_ERROR;
          end
        end
`endif
        ST_DONE:  state <= ST_DONE;
        ST_ERROR: state <= ST_ERROR;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_boot_copier.sv
// ============================================================================
//  Module   : tb_boot_copier
//  Purpose  : Self-checking bench for boot_copier (small image, short
//             timeout, wrapping flash base address).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_boot_copier;

  localparam logic [31:0] FB = 32'hffff_fff8;  // image wraps through 0
  localparam logic [31:0] RB = 32'h0000_0100;
  localparam int          N  = 4;
  localparam int          TO = 16;
`ifdef BOOT_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, start;
  logic [31:0] flash_adr, flash_rdt, ram_adr, ram_dat;
  logic        flash_cyc, flash_ack, ram_we, ram_cyc, ram_ack;
  logic [3:0]  ram_sel;
  logic        busy, cmplt, err;

  boot_copier #(
    .FLASH_ADDRESS (FB),
    .RAM_ADDR      (RB),
    .IMAGE_WORDS   (N),
    .TIMEOUT       (TO)
  ) dut (
    .i_wb_clk       (clk),
    .i_wb_rst       (rst),
    .i_start        (start),
    .o_wb_flash_adr (flash_adr),
    .o_wb_flash_cyc (flash_cyc),
    .i_wb_flash_rdt (flash_rdt),
    .i_wb_flash_ack (flash_ack),
    .o_wb_ram_adr   (ram_adr),
    .o_wb_ram_dat   (ram_dat),
    .o_wb_ram_sel   (ram_sel),
    .o_wb_ram_we    (ram_we),
    .o_wb_ram_cyc   (ram_cyc),
    .i_wb_ram_ack   (ram_ack),
    .o_busy         (busy),
    .o_prog_cmplt   (cmplt),
    .o_error        (err)
  );

  always #5 clk = ~clk;

  // ---------------- slave models ----------------
  logic [31:0] fmem [0:7];
  int          f_delay = 0, r_delay = 0, hang_idx = -1;
  int          fwait = 0, rwait = 0;
  logic [31:0] fidx;

  always_comb begin
    fidx      = (flash_adr - FB) >> 2;
    flash_rdt = (fidx <= 32'(N)) ? fmem[fidx[2:0]] : 32'hdead_beef;
    flash_ack = flash_cyc && (f_delay == 0 || fwait > f_delay) &&
                !(hang_idx >= 0 && fidx == 32'(hang_idx));
    ram_ack   = ram_cyc && (r_delay == 0 || rwait > r_delay);
  end

  // Accepted-transfer logs and bus protocol monitor
  logic [31:0] flog [$];
  logic [63:0] wlog [$];
  int          proto_err = 0;
  logic        p_fcyc = 1'b0, p_rcyc = 1'b0;
  logic [31:0] p_fadr = '0, p_radr = '0, p_rdat = '0;

  always begin
    @(negedge clk);
    fwait = flash_cyc ? fwait + 1 : 0;
    rwait = ram_cyc ? rwait + 1 : 0;
    #1;
    if (flash_cyc && p_fcyc && flash_adr !== p_fadr) proto_err++;
    if (ram_cyc && p_rcyc && (ram_adr !== p_radr || ram_dat !== p_rdat)) proto_err++;
    if (ram_cyc && ram_sel !== 4'hf) proto_err++;
    if (ram_we !== ram_cyc) proto_err++;
    if (flash_cyc && flash_ack) flog.push_back(flash_adr);
    if (ram_cyc && ram_ack) wlog.push_back({ram_adr, ram_dat});
    p_fcyc = flash_cyc; p_rcyc = ram_cyc;
    p_fadr = flash_adr; p_radr = ram_adr; p_rdat = ram_dat;
  end

  // ---------------- checking helpers ----------------
  int n_cmp = 0, n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Raise start and count edges (including the one that samples start)
  // until a sticky status appears; busy must hold meanwhile.
  task automatic run_copy(input int maxc, output int cycles, output int busy_bad);
    start = 1'b1;
    cycles = 0; busy_bad = 0;
    while (cycles < maxc) begin
      @(posedge clk); #1;
      cycles++;
      if (cmplt || err) break;
      if (!busy) busy_bad++;
    end
  endtask

  // Reference: which flash reads and RAM writes the copy should produce,
  // how long it takes, and how it ends.
  logic [31:0] exp_f [$];
  logic [63:0] exp_w [$];
  logic [31:0] img [0:N-1];

  task automatic build_model(input int fd, input int rd, input int hang, output int exp_cyc);
    int stop;
    int p;
    exp_f.delete(); exp_w.delete();
    stop = (hang >= 0) ? hang : N;
    for (int k = 0; k < stop; k++) begin
      exp_f.push_back(FB + 32'(4 * k));
      exp_w.push_back({RB + 32'(4 * k), img[k]});
    end
    p = fd + rd + 4;
    if (hang >= 0) exp_cyc = hang * p + TO + 1;
    else begin
      exp_cyc = N * p;
      if (CK) begin
        exp_f.push_back(FB + 32'(4 * N));
        exp_cyc += fd + 2;
      end
    end
  endtask

  task automatic compare_logs(input string tag);
    check({tag, "_nreads"}, 64'(flog.size()), 64'(exp_f.size()));
    check({tag, "_nwrites"}, 64'(wlog.size()), 64'(exp_w.size()));
    for (int k = 0; k < exp_f.size() && k < flog.size(); k++)
      check({tag, "_rdaddr"}, 64'(flog[k]), 64'(exp_f[k]));
    for (int k = 0; k < exp_w.size() && k < wlog.size(); k++)
      check({tag, "_write"}, wlog[k], exp_w[k]);
  endtask

  task automatic load_image(input int mode, input bit bad);
    logic [31:0] s;
    s = '0;
    for (int k = 0; k < N; k++) begin
      case (mode)
        1:       img[k] = 32'h1111_1111 * 32'(k + 1);
        2:       img[k] = 32'(k + 1);
        default: img[k] = $urandom;
      endcase
      fmem[k] = img[k];
      s += img[k];
    end
    fmem[N] = s + (bad ? 32'd1 : 32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int mode;      // 0 random data, 1 0x11111111.., 2 1..N
    int fd;        // flash wait cycles, -1 = random
    int rd;        // RAM wait cycles, -1 = random
    int hang;      // flash word never acked, -1 = none
    bit bad;       // corrupt checksum trailer
    bit exp_err;   // expected sticky error
  } vec_t;

  vec_t vecs [8];

  initial begin
    int cyc, bb, exp_cyc, fd, rd, act;

    vecs[0] = '{1, 0, 0, -1, 1'b0, 1'b0};
    vecs[1] = '{0, 7, 0, -1, 1'b0, 1'b0};
    vecs[2] = '{0, 0, 0,  2, 1'b0, 1'b1};
    vecs[3] = '{2, 0, 2, -1, 1'b0, 1'b0};
    vecs[4] = '{2, 1, 0, -1, 1'b1, CK};
    vecs[5] = '{0, -1, -1, -1, 1'b0, 1'b0};
    vecs[6] = '{0, -1, -1, -1, 1'b0, 1'b0};
    vecs[7] = '{0, -1, -1,  1, 1'b0, 1'b1};

    rst = 1'b1; start = 1'b0;
    for (int k = 0; k < 8; k++) fmem[k] = '0;
    do_reset();
    #1;
    check("rst_flash", {flash_adr, 31'b0, flash_cyc}, 64'd0);
    check("rst_ram", {ram_adr, ram_dat}, 64'd0);
    check("rst_ctl", 64'({ram_sel, ram_we, ram_cyc, busy, cmplt, err}), 64'd0);

    foreach (vecs[i]) begin
      do_reset();
      fd = (vecs[i].fd < 0) ? int'($urandom_range(0, 3)) : vecs[i].fd;
      rd = (vecs[i].rd < 0) ? int'($urandom_range(0, 3)) : vecs[i].rd;
      f_delay = fd; r_delay = rd; hang_idx = vecs[i].hang;
      load_image(vecs[i].mode, vecs[i].bad);
      flog.delete(); wlog.delete();
      build_model(fd, rd, vecs[i].hang, exp_cyc);
      run_copy(400, cyc, bb);
      check($sformatf("v%0d_cycles", i), 64'(cyc), 64'(exp_cyc));
      check($sformatf("v%0d_cmplt", i), 64'(cmplt), 64'(!vecs[i].exp_err));
      check($sformatf("v%0d_error", i), 64'(err), 64'(vecs[i].exp_err));
      check($sformatf("v%0d_busy_during", i), 64'(bb), 64'd0);
      check($sformatf("v%0d_idle_after", i), 64'({busy, flash_cyc, ram_cyc}), 64'd0);
      compare_logs($sformatf("v%0d", i));
    end

    // Reset while word 1 is being written; start held, copy must restart at 0
    do_reset();
    f_delay = 0; r_delay = 3; hang_idx = -1;
    load_image(0, 1'b0);
    flog.delete(); wlog.delete();
    start = 1'b1;
    act = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (wlog.size() == 1 && ram_cyc) begin act = 1; break; end
    end
    check("midrst_reached_word1", 64'(act), 64'd1);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_outputs_a", {flash_adr, ram_adr}, 64'd0);
    check("midrst_outputs_b", {ram_dat, 24'b0, ram_sel, flash_cyc, ram_we, ram_cyc, busy, cmplt, err}, 64'd0);
    @(negedge clk); rst = 1'b0;
    flog.delete(); wlog.delete();
    build_model(0, 3, -1, exp_cyc);
    run_copy(400, cyc, bb);
    check("midrst_cycles", 64'(cyc), 64'(exp_cyc));
    check("midrst_cmplt", 64'(cmplt), 64'd1);
    compare_logs("midrst");

    // Toggling start after DONE must not start new transfers
    act = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk); start = k[0];
      @(posedge clk); #1;
      if (flash_cyc || ram_cyc || busy) act++;
    end
    check("done_no_activity", 64'(act), 64'd0);
    check("done_sticky", 64'({cmplt, err}), 64'b10);
    check("done_log_unchanged", 64'(wlog.size()), 64'(N));

    check("protocol_violations", 64'(proto_err), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
